// File: rtl/motor_pwm_driver.sv
// Fixed-frequency H-bridge PWM driver with ramped duty and direction interlock.
// `MOTOR_PWM_SOFT_STOP_EN selects a ramped stop; the default build hard-stops on a stop request.
module motor_pwm_driver #(
    parameter logic [11:0] PERIOD    = 12'd2500,
    parameter logic [11:0] RAMP_STEP = 12'd5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MOTOR_EN,
    input  logic        MOTOR_DIR,
    input  logic [11:0] DUTY_SET,
    output logic        PWM_OUT,
    output logic        DIR_OUT,
    output logic        RUNNING,
    output logic        AT_SPEED,
    output logic [1:0]  dbg_state_o,
    output logic [11:0] dbg_duty_o,
    output logic [11:0] dbg_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q;
    logic [11:0] duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        pwm_q, running_q, at_speed_q;

    logic        tick;
    logic        stop_req;
    logic [11:0] set_clamped;
    logic [11:0] tgt;
    logic [12:0] up_sum;
    logic [12:0] dn_floor;
    logic [11:0] stepped;

    assign tick        = (cnt_q == PERIOD - 12'd1);
    assign stop_req    = !MOTOR_EN || (MOTOR_DIR != dir_q);
    assign set_clamped = (DUTY_SET > PERIOD) ? PERIOD : DUTY_SET;
    assign tgt         = (state_q == STOP) ? 12'd0 : set_clamped;

    // One ramp step toward tgt, saturating at tgt; 13-bit so neither direction wraps.
    always_comb begin
        up_sum   = {1'b0, duty_q} + {1'b0, RAMP_STEP};
        dn_floor = {1'b0, tgt} + {1'b0, RAMP_STEP};
        stepped  = duty_q;
        if (duty_q < tgt) begin
            stepped = (up_sum > {1'b0, tgt}) ? tgt : up_sum[11:0];
        end else if (duty_q > tgt) begin
            stepped = ({1'b0, duty_q} < dn_floor) ? tgt : (duty_q - RAMP_STEP);
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                duty_d = 12'd0;
                dir_d  = MOTOR_DIR;
                if (MOTOR_EN) state_d = RAMP;
            end
            RAMP: begin
                if (tick) begin
                    duty_d = stepped;
                    if (stepped == tgt) state_d = RUN;
                end
`ifdef MOTOR_PWM_SOFT_STOP_EN
                if (stop_req) state_d = STOP;
`else
                if (stop_req) begin
                    state_d = IDLE;
                    duty_d  = 12'd0;
                end
`endif
            end
            RUN: begin
                // A new target is only acted on at a period boundary.
                if (tick && (tgt != duty_q)) begin
                    duty_d = stepped;
                    if (stepped != tgt) state_d = RAMP;
                end
`ifdef MOTOR_PWM_SOFT_STOP_EN
                if (stop_req) state_d = STOP;
`else
                if (stop_req) begin
                    state_d = IDLE;
                    duty_d  = 12'd0;
                end
`endif
            end
            STOP: begin
                if (tick) begin
                    duty_d = stepped;
                    if (stepped == 12'd0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= 12'd0;
            state_q    <= IDLE;
            duty_q     <= 12'd0;
            dir_q      <= 1'b0;
            pwm_q      <= 1'b0;
            running_q  <= 1'b0;
            at_speed_q <= 1'b0;
        end else begin
            cnt_q      <= tick ? 12'd0 : cnt_q + 12'd1;
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            pwm_q      <= (cnt_q < duty_q);
            running_q  <= (state_q != IDLE);
            at_speed_q <= (state_q == RUN);
        end
    end

    assign PWM_OUT     = pwm_q;
    assign DIR_OUT     = dir_q;
    assign RUNNING     = running_q;
    assign AT_SPEED    = at_speed_q;
    assign dbg_state_o = state_q;
    assign dbg_duty_o  = duty_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver with PERIOD=10, RAMP_STEP=2; a monitor checks every duty update against a queue.
module tb_motor_pwm_driver;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic        clk;
    logic        rst;
    logic        motor_en;
    logic        motor_dir;
    logic [11:0] duty_set;
    logic        pwm_out, dir_out, running, at_speed;
    logic [1:0]  dbg_state;
    logic [11:0] dbg_duty, dbg_cnt;

    logic [11:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic [11:0] last_duty;
    int          hi_cnt;

    motor_pwm_driver #(
        .PERIOD    (12'd10),
        .RAMP_STEP (12'd2)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .MOTOR_EN    (motor_en),
        .MOTOR_DIR   (motor_dir),
        .DUTY_SET    (duty_set),
        .PWM_OUT     (pwm_out),
        .DIR_OUT     (dir_out),
        .RUNNING     (running),
        .AT_SPEED    (at_speed),
        .dbg_state_o (dbg_state),
        .dbg_duty_o  (dbg_duty),
        .dbg_cnt_o   (dbg_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_duty(input int val, input string name);
        int n;
        n = 0;
        while ((dbg_duty !== val[11:0]) && (n < 400)) begin
            step();
            n++;
        end
        chk({name, "_reached"}, int'(dbg_duty), val);
    endtask

    task automatic wait_cnt(input int val);
        int n;
        n = 0;
        while ((dbg_cnt !== val[11:0]) && (n < 40)) begin
            step();
            n++;
        end
        if (dbg_cnt !== val[11:0]) chk("cnt_sync", int'(dbg_cnt), val);
    endtask

    // Counts high cycles of PWM_OUT across one full period, cnt=0..9.
    task automatic count_pwm(output int n);
        wait_cnt(1);
        n = int'(pwm_out);
        for (int i = 0; i < 9; i++) begin
            step();
            n += int'(pwm_out);
        end
    endtask

    // Scoreboard monitor: each duty update must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && (dbg_duty !== last_duty)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL duty_unexpected actual=%0d expected=none", dbg_duty);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (dbg_duty !== e) begin
                    failures++;
                    $display("FAIL duty_update actual=%0d expected=%0d", dbg_duty, e);
                end
            end
        end
        last_duty = dbg_duty;
    end

    initial begin
        rst       = 1'b1;
        motor_en  = 1'b0;
        motor_dir = 1'b0;
        duty_set  = 12'd0;

        // 1. Reset
        repeat (3) step();
        rst = 1'b0;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_dir", int'(dir_out), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_at_speed", int'(at_speed), 0);
        chk("rst_cnt", int'(dbg_cnt), 0);
        chk("rst_duty", int'(dbg_duty), 0);
        chk("rst_state", int'(dbg_state), int'(S_IDLE));
        last_duty = dbg_duty;
        mon_en    = 1'b1;
        step();

        // 2. Ramp up to 6
        duty_set = 12'd6;
        motor_en = 1'b1;
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd4);
        exp_q.push_back(12'd6);
        step();
        chk("ramp_state", int'(dbg_state), int'(S_RAMP));
        wait_duty(6, "ramp6");
        chk("ramp6_at_speed_lag", int'(at_speed), 0);
        step();
        chk("ramp6_at_speed", int'(at_speed), 1);
        chk("ramp6_running", int'(running), 1);
        count_pwm(hi_cnt);
        chk("pwm_high_6", hi_cnt, 6);

        // 3. Clamp above PERIOD
        duty_set = 12'd15;
        exp_q.push_back(12'd8);
        exp_q.push_back(12'd10);
        wait_duty(10, "clamp10");
        step();
        chk("clamp_state", int'(dbg_state), int'(S_RUN));
        chk("clamp_at_speed", int'(at_speed), 1);
        count_pwm(hi_cnt);
        chk("pwm_high_full", hi_cnt, 10);

        duty_set = 12'd6;
        exp_q.push_back(12'd8);
        exp_q.push_back(12'd6);
        wait_duty(6, "back6");
        step();
        chk("back6_state", int'(dbg_state), int'(S_RUN));

`ifdef MOTOR_PWM_SOFT_STOP_EN
        // 4. Soft reversal
        motor_dir = 1'b1;
        exp_q.push_back(12'd4);
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd0);
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd4);
        exp_q.push_back(12'd6);
        wait_duty(2, "rev_down2");
        chk("rev_dir_held", int'(dir_out), 0);
        chk("rev_running", int'(running), 1);
        wait_duty(0, "rev_zero");
        chk("rev_idle", int'(dbg_state), int'(S_IDLE));
        chk("rev_dir_before", int'(dir_out), 0);
        step();
        chk("rev_dir_after", int'(dir_out), 1);
        wait_duty(6, "rev_up6");
        step();
        chk("rev_at_speed", int'(at_speed), 1);
        count_pwm(hi_cnt);
        chk("rev_pwm_high_6", hi_cnt, 6);

        // Soft stop back to idle before the reset scenario
        motor_en = 1'b0;
        exp_q.push_back(12'd4);
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd0);
        wait_duty(0, "soft_stop0");
        step();
        chk("soft_stop_idle", int'(dbg_state), int'(S_IDLE));
`else
        // 5. Hard stop mid-period
        wait_cnt(4);
        motor_en = 1'b0;
        exp_q.push_back(12'd0);
        step();
        chk("hard_state_idle", int'(dbg_state), int'(S_IDLE));
        chk("hard_duty0", int'(dbg_duty), 0);
        chk("hard_running_lag", int'(running), 1);
        step();
        chk("hard_pwm0", int'(pwm_out), 0);
        chk("hard_running0", int'(running), 0);
        chk("hard_at_speed0", int'(at_speed), 0);
`endif

        // 6. Reset during ramp
        motor_en = 1'b1;
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd4);
        wait_duty(4, "pre_rst4");
        exp_q.push_back(12'd0);
        rst = 1'b1;
        step();
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_running", int'(running), 0);
        chk("mid_rst_duty", int'(dbg_duty), 0);
        chk("mid_rst_cnt", int'(dbg_cnt), 0);
        chk("mid_rst_state", int'(dbg_state), int'(S_IDLE));
        chk("mid_rst_dir", int'(dir_out), 0);
        rst = 1'b0;
        exp_q.push_back(12'd2);
        exp_q.push_back(12'd4);
        exp_q.push_back(12'd6);
        wait_duty(6, "restart6");
        step();
        chk("restart_at_speed", int'(at_speed), 1);
        chk("restart_dir", int'(dir_out), int'(motor_dir));
        count_pwm(hi_cnt);
        chk("restart_pwm_high_6", hi_cnt, 6);

        step();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
